demux1to8_bank: RTL and testbench

- Registered 1-to-8 demultiplexer bank. It is the inverse path of the ALU's 8-to-1 result select.
- Takes one WIDTH-bit word per accepted transfer and steers it into one of eight holding slots.
- Slot selection is either the explicit opsel, or an internal wrap-around pointer (sequential/deserialize mode).
- Each slot has its own valid flag, cleared by a per-slot consumer ack. A full slot back-pressures the producer.

---
 rtl/demux1to8_bank.sv | 87 ++++++++
 tb/tb_demux1to8_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to8_bank.sv
// Registered 1-to-8 demultiplexer bank: steers each accepted word into one of eight
// holding slots chosen by opsel or by a wrap-around sequential pointer.
module demux1to8_bank #(
   parameter int WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           opsel,
   input  logic                 seq_mode,
   output logic [8*WIDTH-1:0]   out_bus,
   output logic [7:0]           out_valid,
   input  logic [7:0]           out_ack,
   output logic [2:0]           ptr,
   output logic                 frame_done,
   output logic                 all_full
);

   localparam int NSLOT = 8;

   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       tgt;
   logic [NSLOT-1:0] valid_q, valid_d;
   logic [NSLOT-1:0] wr_sel;
   logic             frame_q, frame_d;
   logic             accept;

   // Ready is purely combinational so a slot acked this cycle can be refilled this cycle.
   assign tgt      = seq_mode ? ptr_q : opsel;
   assign in_ready = !rst && (!valid_q[tgt] || out_ack[tgt]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_sel = '0;
      if (accept) begin
         wr_sel[tgt] = 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
         logic [WIDTH-1:0] data_q;

         // A write to the slot overrides a same-cycle ack.
         assign valid_d[gi] = wr_sel[gi] | (valid_q[gi] & ~out_ack[gi]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q <= '0;
            end else if (wr_sel[gi]) begin
               data_q <= in_data;
            end
         end

         assign out_bus[gi*WIDTH +: WIDTH] = data_q;
      end
   endgenerate

   always_comb begin
      ptr_d   = ptr_q;
      frame_d = 1'b0;
      if (accept && seq_mode) begin
         ptr_d   = ptr_q + 3'd1;
         frame_d = (ptr_q == 3'd7);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         ptr_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         frame_q <= frame_d;
      end
   end

   assign out_valid  = valid_q;
   assign ptr        = ptr_q;
   assign frame_done = frame_q;
   assign all_full   = &valid_q;

endmodule

// File: tb/tb_demux1to8_bank.sv
// Self-checking bench for demux1to8_bank: directed scenarios plus a randomized run
// checked against a slot/flag/pointer array model.
module tb_demux1to8_bank;

   localparam int W = 128;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     opsel;
   logic           seq_mode;
   logic [8*W-1:0] out_bus;
   logic [7:0]     out_valid;
   logic [7:0]     out_ack;
   logic [2:0]     ptr;
   logic           frame_done;
   logic           all_full;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [W-1:0] m_slot [8];
   logic [7:0]   m_valid;
   int           m_ptr;
   logic         m_frame;
   logic         exp_ready;
   logic         obs_ready;

   demux1to8_bank #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opsel      (opsel),
      .seq_mode   (seq_mode),
      .out_bus    (out_bus),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .ptr        (ptr),
      .frame_done (frame_done),
      .all_full   (all_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [8*W-1:0] exp_bus();
      logic [8*W-1:0] b;
      for (int i = 0; i < 8; i++) b[i*W +: W] = m_slot[i];
      return b;
   endfunction

   function automatic logic [W-1:0] slot_of(input int i);
      return out_bus[i*W +: W];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_slot[i] = '0;
      m_valid = '0;
      m_ptr   = 0;
      m_frame = 1'b0;
   endtask

   // Called at a falling edge; applies inputs for one cycle and returns at the next falling edge.
   task automatic step(input logic v, input logic [2:0] sel, input logic sm,
                       input logic [W-1:0] d, input logic [7:0] ack);
      int   t;
      logic acc;
      in_valid = v; opsel = sel; seq_mode = sm; in_data = d; out_ack = ack;
      #1;
      obs_ready = in_ready;
      t = sm ? m_ptr : int'(sel);
      exp_ready = !m_valid[t] || ack[t];
      acc = v && exp_ready;
      @(posedge clk);
      m_valid = m_valid & ~ack;
      m_frame = acc && sm && (m_ptr == 7);
      if (acc) begin
         m_slot[t]  = d;
         m_valid[t] = 1'b1;
         if (sm) m_ptr = (m_ptr + 1) % 8;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ack  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ack = '0; opsel = '0; seq_mode = 1'b0; in_data = '0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ack = '0; opsel = '0; seq_mode = 1'b0; in_data = 128'h1234;
      model_clear();
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid: got %h want 00", out_valid); end
      total++; if (ptr !== 3'd0 || frame_done !== 1'b0 || all_full !== 1'b0) begin
         bad++; $display("FAIL reset_ptr_frame_full: got %0d/%b/%b want 0/0/0", ptr, frame_done, all_full); end
      total++; if (out_bus !== '0) begin bad++; $display("FAIL reset_bus: got %h want 0", out_bus); end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_explicit();
      do_reset();
      step(1'b1, 3'd5, 1'b0, 128'hA5, 8'h00);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL explicit_ready: got %b want 1", obs_ready); end
      total++; if (out_valid !== 8'h20) begin bad++; $display("FAIL explicit_valid: got %h want 20", out_valid); end
      total++; if (slot_of(5) !== 128'hA5) begin bad++; $display("FAIL explicit_slot5: got %h want a5", slot_of(5)); end
      total++; if (ptr !== 3'd0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL explicit_ptr_frame: got %0d/%b want 0/0", ptr, frame_done); end
      step(1'b1, 3'd7, 1'b0, 128'h77, 8'h00);
      total++; if (frame_done !== 1'b0 || ptr !== 3'd0) begin
         bad++; $display("FAIL explicit_slot7_no_frame: got %b/%0d want 0/0", frame_done, ptr); end
   endtask

   task automatic test_seq_fill();
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 3'd0, 1'b1, W'(k), 8'h00);
         total++; if (frame_done !== (k == 8)) begin
            bad++; $display("FAIL seq_frame_%0d: got %b want %b", k, frame_done, (k == 8)); end
         total++; if (int'(ptr) !== k % 8) begin
            bad++; $display("FAIL seq_ptr_%0d: got %0d want %0d", k, ptr, k % 8); end
      end
      for (int i = 0; i < 8; i++) begin
         total++; if (slot_of(i) !== W'(i + 1)) begin
            bad++; $display("FAIL seq_slot%0d: got %h want %h", i, slot_of(i), W'(i + 1)); end
      end
      total++; if (out_valid !== 8'hFF || all_full !== 1'b1) begin
         bad++; $display("FAIL seq_full: got %h/%b want ff/1", out_valid, all_full); end
      step(1'b1, 3'd0, 1'b1, 128'h9, 8'h00);
      total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL seq_9th_ready: got %b want 0", obs_ready); end
      total++; if (ptr !== 3'd0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL seq_9th_hold: got %0d/%b want 0/0", ptr, frame_done); end
      total++; if (slot_of(0) !== 128'h1) begin bad++; $display("FAIL seq_9th_slot0: got %h want 1", slot_of(0)); end
   endtask

   task automatic test_backpressure();
      // bank is full from the previous scenario
      for (int c = 1; c <= 3; c++) begin
         step(1'b1, 3'd2, 1'b0, 128'hBEEF, (c == 3) ? 8'h04 : 8'h00);
         total++; if (obs_ready !== (c == 3)) begin
            bad++; $display("FAIL bp_ready_c%0d: got %b want %b", c, obs_ready, (c == 3)); end
      end
      total++; if (slot_of(2) !== 128'hBEEF) begin bad++; $display("FAIL bp_slot2: got %h want beef", slot_of(2)); end
      total++; if (out_valid !== 8'hFF) begin bad++; $display("FAIL bp_write_wins: got %h want ff", out_valid); end
   endtask

   task automatic test_ack_all();
      step(1'b0, 3'd0, 1'b0, '0, 8'h7E);
      total++; if (out_valid !== 8'h81) begin bad++; $display("FAIL ack_partial: got %h want 81", out_valid); end
      step(1'b0, 3'd0, 1'b0, '0, 8'hFF);
      total++; if (out_valid !== 8'h00 || all_full !== 1'b0) begin
         bad++; $display("FAIL ack_all_valid: got %h/%b want 00/0", out_valid, all_full); end
      total++; if (out_bus !== exp_bus()) begin bad++; $display("FAIL ack_data_kept: got %h want %h", out_bus, exp_bus()); end
      step(1'b0, 3'd0, 1'b0, '0, 8'hFF);
      total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL ack_empty: got %h want 00", out_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 3'd0, 1'b1, W'(32'hC0 + k), 8'h00);
      total++; if (ptr !== 3'd4 || out_valid !== 8'h0F) begin
         bad++; $display("FAIL areset_pre: got %0d/%h want 4/0f", ptr, out_valid); end
      in_valid = 1'b1; seq_mode = 1'b1; in_data = 128'hDEAD;
      #2;
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL areset_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 8'h00 || ptr !== 3'd0) begin
         bad++; $display("FAIL areset_state: got %h/%0d want 00/0", out_valid, ptr); end
      total++; if (out_bus !== '0) begin bad++; $display("FAIL areset_bus: got %h want 0", out_bus); end
      in_valid = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 8'h00 || ptr !== 3'd0) begin
         bad++; $display("FAIL areset_discard: got %h/%0d want 00/0", out_valid, ptr); end
   endtask

   task automatic test_mode_toggle();
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 3'd6, 1'b1, W'(32'h30 + k), 8'h00);
      step(1'b1, 3'd6, 1'b0, 128'h66, 8'h00);
      total++; if (slot_of(6) !== 128'h66 || out_valid !== 8'h47) begin
         bad++; $display("FAIL toggle_slot6: got %h/%h want 66/47", slot_of(6), out_valid); end
      total++; if (ptr !== 3'd3) begin bad++; $display("FAIL toggle_ptr: got %0d want 3", ptr); end
   endtask

   task automatic test_random();
      logic sm;
      do_reset();
      sm = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) sm = ~sm;
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), sm,
              {$urandom, $urandom, $urandom, $urandom}, 8'($urandom & $urandom));
         total++; if (obs_ready !== exp_ready) begin
            bad++; $display("FAIL rnd_ready_%0d: got %b want %b", n, obs_ready, exp_ready); end
         total++; if (out_valid !== m_valid || all_full !== (&m_valid)) begin
            bad++; $display("FAIL rnd_valid_%0d: got %h/%b want %h/%b", n, out_valid, all_full, m_valid, &m_valid); end
         total++; if (int'(ptr) !== m_ptr || frame_done !== m_frame) begin
            bad++; $display("FAIL rnd_ptr_frame_%0d: got %0d/%b want %0d/%b", n, ptr, frame_done, m_ptr, m_frame); end
         for (int i = 0; i < 8; i++) begin
            total++; if (slot_of(i) !== m_slot[i]) begin
               bad++; $display("FAIL rnd_slot%0d_%0d: got %h want %h", i, n, slot_of(i), m_slot[i]); end
         end
      end
   endtask

   initial begin
      in_valid = 1'b0; out_ack = '0; opsel = '0; seq_mode = 1'b0; in_data = '0; rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_explicit();
      test_seq_fill();
      test_backpressure();
      test_ack_all();
      test_async_reset();
      test_mode_toggle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
